// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory-access stage between EX/MEM and MEM/WB.
// Issues word-wide loads/stores over a req/ack handshake, stalls EX/MEM
// while an access is outstanding, resolves branch/jump PC selection for
// non-memory instructions and registers the MEM/WB values.
// Optional feature: define MEM_TIMEOUT_EN to add an ack watchdog that
// abandons an access after TIMEOUT_CYCLES and returns ERR_DATA.
module mem_stage_unit #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWriteFlagInput,
  input  logic        MemToRegInput,
  input  logic        memReadFlagInput,
  input  logic        memWriteFlagInput,
  input  logic        BranchsFlagInput,
  input  logic        JumpsFlagInput,
  input  logic        ZeroFlagInput,
  input  logic [31:0] ResultInput,
  input  logic [31:0] BInput,
  input  logic [4:0]  regDestAddressInput,
  input  logic [31:0] BranchAddressInput,
  input  logic [31:0] JumpAddressInput,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck,
  output logic        stallOutput,
  output logic [1:0]  pcSrcOutput,
  output logic [31:0] targetOutput,
  output logic        regWriteFlagOutput,
  output logic        MemToRegOutput,
  output logic [31:0] readDataOutput,
  output logic [31:0] ResultOutput,
  output logic [4:0]  regDestAddressOutput,
  output logic        validOutput,
  output logic        alignErrOutput,
  output logic        timeoutOutput
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic isMemOp;
  logic isAligned;
  logic accessStart;
  logic misaligned;
  logic timeoutHit;

  // Instruction fields captured when an access starts, retired at DONE.
  logic        pendRegWrite;
  logic        pendMemToReg;
  logic [4:0]  pendDest;
  logic [31:0] pendResult;

  assign isMemOp     = memReadFlagInput | memWriteFlagInput;
  assign isAligned   = (ResultInput[1:0] == 2'b00);
  assign accessStart = isMemOp & isAligned;
  assign misaligned  = isMemOp & ~isAligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] accessCount;
  logic             timeoutFlag;

  assign timeoutHit = (state == ACCESS) && !memAck &&
                      (accessCount == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeoutOutput = timeoutFlag;

  // Count cycles spent in ACCESS; restart from zero for every access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accessCount <= '0;
    end else if (state != ACCESS) begin
      accessCount <= '0;
    end else begin
      accessCount <= accessCount + CNT_W'(1);
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeoutFlag <= 1'b0;
    end else if (timeoutHit) begin
      timeoutFlag <= 1'b1;
    end
  end
`else
  assign timeoutHit    = 1'b0;
  assign timeoutOutput = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, handshake, stall and PC-select decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    stateNext    = state;
    memReq       = 1'b0;
    stallOutput  = 1'b0;
    pcSrcOutput  = 2'd0;
    targetOutput = 32'h0;
    case (state)
      IDLE: begin
        if (accessStart) begin
          stateNext   = ACCESS;
          stallOutput = 1'b1;
        end else if (!isMemOp) begin
          if (JumpsFlagInput) begin
            pcSrcOutput  = 2'd2;
            targetOutput = JumpAddressInput;
          end else if (BranchsFlagInput && ZeroFlagInput) begin
            pcSrcOutput  = 2'd1;
            targetOutput = BranchAddressInput;
          end
        end
      end
      ACCESS: begin
        memReq      = 1'b1;
        stallOutput = 1'b1;
        if (memAck || timeoutHit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    // Reset drops the request and stall immediately, even mid-access.
    if (rst) begin
      memReq       = 1'b0;
      stallOutput  = 1'b0;
      pcSrcOutput  = 2'd0;
      targetOutput = 32'h0;
    end
  end

  // Capture request and retiring instruction fields when an access starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memWe        <= 1'b0;
      memAddr      <= 32'h0;
      memWData     <= 32'h0;
      pendRegWrite <= 1'b0;
      pendMemToReg <= 1'b0;
      pendDest     <= 5'd0;
      pendResult   <= 32'h0;
    end else if (state == IDLE && accessStart) begin
      // Write wins when both read and write are flagged.
      memWe        <= memWriteFlagInput;
      memAddr      <= ResultInput;
      memWData     <= BInput;
      pendRegWrite <= regWriteFlagInput & ~memWriteFlagInput;
      pendMemToReg <= MemToRegInput;
      pendDest     <= regDestAddressInput;
      pendResult   <= ResultInput;
    end
  end

  // MEM/WB register: retire, bubble while stalled, capture load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteFlagOutput   <= 1'b0;
      MemToRegOutput       <= 1'b0;
      readDataOutput       <= 32'h0;
      ResultOutput         <= 32'h0;
      regDestAddressOutput <= 5'd0;
      validOutput          <= 1'b0;
      alignErrOutput       <= 1'b0;
    end else begin
      alignErrOutput <= 1'b0;
      case (state)
        IDLE: begin
          if (accessStart) begin
            validOutput        <= 1'b0;
            regWriteFlagOutput <= 1'b0;
          end else begin
            validOutput          <= 1'b1;
            regWriteFlagOutput   <= regWriteFlagInput & ~misaligned;
            MemToRegOutput       <= MemToRegInput;
            ResultOutput         <= ResultInput;
            regDestAddressOutput <= regDestAddressInput;
            alignErrOutput       <= misaligned;
          end
        end
        ACCESS: begin
          validOutput        <= 1'b0;
          regWriteFlagOutput <= 1'b0;
          if (memAck) begin
            readDataOutput <= memRData;
          end else if (timeoutHit) begin
            readDataOutput <= ERR_DATA;
          end
        end
        DONE: begin
          validOutput          <= 1'b1;
          regWriteFlagOutput   <= pendRegWrite;
          MemToRegOutput       <= pendMemToReg;
          ResultOutput         <= pendResult;
          regDestAddressOutput <= pendDest;
        end
        default: begin
          validOutput        <= 1'b0;
          regWriteFlagOutput <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: directed bench for mem_stage_unit with a
// transaction-level model of the expected pipeline timeline.
// Define MEM_TIMEOUT_EN to also exercise the ack watchdog (limit 4).
module tb_mem_stage_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  typedef struct packed {
    logic        rw, m2r, rd, wr, br, jmp, zero;
    logic [31:0] res, b, bAddr, jAddr;
    logic [4:0]  dest;
  } instrT;

  // Architectural MEM/WB view expected at the DUT outputs.
  typedef struct packed {
    logic        valid, rw, m2r, align, tmo;
    logic [31:0] rdata, res;
    logic [4:0]  dest;
  } wbT;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWriteFlagInput, MemToRegInput, memReadFlagInput, memWriteFlagInput;
  logic        BranchsFlagInput, JumpsFlagInput, ZeroFlagInput;
  logic [31:0] ResultInput, BInput, BranchAddressInput, JumpAddressInput;
  logic [4:0]  regDestAddressInput;
  logic        memReq, memWe, memAck;
  logic [31:0] memAddr, memWData, memRData;
  logic        stallOutput;
  logic [1:0]  pcSrcOutput;
  logic [31:0] targetOutput;
  logic        regWriteFlagOutput, MemToRegOutput, validOutput, alignErrOutput, timeoutOutput;
  logic [31:0] readDataOutput, ResultOutput;
  logic [4:0]  regDestAddressOutput;

  mem_stage_unit #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .ERR_DATA      (32'hDEADBEEF)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .regWriteFlagInput   (regWriteFlagInput),
    .MemToRegInput       (MemToRegInput),
    .memReadFlagInput    (memReadFlagInput),
    .memWriteFlagInput   (memWriteFlagInput),
    .BranchsFlagInput    (BranchsFlagInput),
    .JumpsFlagInput      (JumpsFlagInput),
    .ZeroFlagInput       (ZeroFlagInput),
    .ResultInput         (ResultInput),
    .BInput              (BInput),
    .regDestAddressInput (regDestAddressInput),
    .BranchAddressInput  (BranchAddressInput),
    .JumpAddressInput    (JumpAddressInput),
    .memReq              (memReq),
    .memWe               (memWe),
    .memAddr             (memAddr),
    .memWData            (memWData),
    .memRData            (memRData),
    .memAck              (memAck),
    .stallOutput         (stallOutput),
    .pcSrcOutput         (pcSrcOutput),
    .targetOutput        (targetOutput),
    .regWriteFlagOutput  (regWriteFlagOutput),
    .MemToRegOutput      (MemToRegOutput),
    .readDataOutput      (readDataOutput),
    .ResultOutput        (ResultOutput),
    .regDestAddressOutput(regDestAddressOutput),
    .validOutput         (validOutput),
    .alignErrOutput      (alignErrOutput),
    .timeoutOutput       (timeoutOutput)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFails = 0;
  int stallCount = 0;
  logic cmpEn = 1'b0;
  logic strayAck = 1'b0;

  // Model state: registered view (cur/nxt) and per-cycle handshake view.
  wbT          cur, nxt;
  logic        eReq, eStall, eWe;
  logic [31:0] eAddr, eWData, eTgt;
  logic [1:0]  ePc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      check("memReq", memReq, eReq);
      check("stall", stallOutput, eStall);
      check("pcSrc", pcSrcOutput, ePc);
      check("target", targetOutput, eTgt);
      check("memWe", memWe, eWe);
      check("memAddr", memAddr, eAddr);
      check("memWData", memWData, eWData);
      check("valid", validOutput, cur.valid);
      check("regWrite", regWriteFlagOutput, cur.rw);
      check("memToReg", MemToRegOutput, cur.m2r);
      check("readData", readDataOutput, cur.rdata);
      check("result", ResultOutput, cur.res);
      check("dest", regDestAddressOutput, cur.dest);
      check("alignErr", alignErrOutput, cur.align);
      check("timeout", timeoutOutput, cur.tmo);
    end
  end

  always @(negedge clk) begin
    if (stallOutput === 1'b1) stallCount++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic instrT mk(input logic rw, m2r, rd, wr, br, jmp, zero,
                               input logic [31:0] res, b, bAddr, jAddr,
                               input logic [4:0] dest);
    instrT i;
    i.rw = rw; i.m2r = m2r; i.rd = rd; i.wr = wr; i.br = br; i.jmp = jmp; i.zero = zero;
    i.res = res; i.b = b; i.bAddr = bAddr; i.jAddr = jAddr; i.dest = dest;
    return i;
  endfunction

  task automatic drive(input instrT i);
    regWriteFlagInput   = i.rw;
    MemToRegInput       = i.m2r;
    memReadFlagInput    = i.rd;
    memWriteFlagInput   = i.wr;
    BranchsFlagInput    = i.br;
    JumpsFlagInput      = i.jmp;
    ZeroFlagInput       = i.zero;
    ResultInput         = i.res;
    BInput              = i.b;
    BranchAddressInput  = i.bAddr;
    JumpAddressInput    = i.jAddr;
    regDestAddressInput = i.dest;
  endtask

  // Next-PC rule: only non-memory instructions redirect.
  task automatic resolve(input instrT i, output logic [1:0] pc, output logic [31:0] tgt);
    if (i.rd || i.wr) begin pc = 2'd0; tgt = 32'h0; end
    else if (i.jmp) begin pc = 2'd2; tgt = i.jAddr; end
    else if (i.br && i.zero) begin pc = 2'd1; tgt = i.bAddr; end
    else begin pc = 2'd0; tgt = 32'h0; end
  endtask

  // Advance one clock: last cycle's retirement becomes visible.
  task automatic tick();
    @(posedge clk);
    #1;
    cur = nxt;
    nxt = cur;
    nxt.align = 1'b0;
  endtask

  task automatic modelReset();
    cur = '0; nxt = '0;
    eReq = 0; eStall = 0; eWe = 0; eAddr = 0; eWData = 0; ePc = 0; eTgt = 0;
  endtask

  // Present one instruction and follow it through to retirement.
  task automatic exec(input instrT i, input int waits, input logic [31:0] rdata);
    logic isMem, aligned;
    logic [1:0] pc;
    logic [31:0] tgt;
    isMem   = i.rd | i.wr;
    aligned = (i.res[1:0] == 2'b00);
    tick();
    drive(i);
    resolve(i, pc, tgt);
    ePc = pc; eTgt = tgt;
    if (!(isMem && aligned)) begin
      memAck = strayAck; memRData = 32'hBADBAD00;
      eReq = 0; eStall = 0;
      nxt.valid = 1; nxt.rw = i.rw & ~isMem; nxt.m2r = i.m2r;
      nxt.res = i.res; nxt.dest = i.dest; nxt.align = isMem;
    end else begin
      memAck = 0; memRData = 32'h0;
      eReq = 0; eStall = 1;
      nxt.valid = 0; nxt.rw = 0;
      for (int k = 0; k <= waits; k++) begin
        tick();
        eReq = 1; eStall = 1; eWe = i.wr; eAddr = i.res; eWData = i.b;
        memAck   = (k == waits);
        memRData = (k == waits) ? rdata : 32'h0;
        nxt.valid = 0; nxt.rw = 0;
        if (k == waits) nxt.rdata = rdata;
      end
      tick();
      memAck = strayAck; memRData = 32'hBADBAD00;
      eReq = 0; eStall = 0;
      nxt.valid = 1; nxt.rw = i.rw & ~i.wr; nxt.m2r = i.m2r;
      nxt.res = i.res; nxt.dest = i.dest;
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic execTimeoutLoad(input instrT i);
    tick();
    drive(i);
    ePc = 0; eTgt = 0; memAck = 0; memRData = 32'h0;
    eReq = 0; eStall = 1; nxt.valid = 0; nxt.rw = 0;
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      tick();
      eReq = 1; eStall = 1; eWe = i.wr; eAddr = i.res; eWData = i.b;
      if (k == TB_TIMEOUT - 1) begin
        nxt.rdata = 32'hDEADBEEF;
        nxt.tmo   = 1'b1;
      end
    end
    tick();
    eReq = 0; eStall = 0;
    nxt.valid = 1; nxt.rw = i.rw & ~i.wr; nxt.m2r = i.m2r;
    nxt.res = i.res; nxt.dest = i.dest;
  endtask
`endif

  task automatic releaseReset(input instrT nop);
    @(negedge clk);
    rst = 0;
    nxt = '0;
    nxt.valid = 1;
    exec(nop, 0, 32'h0);
    cmpEn = 1;
  endtask

  initial begin
    instrT nop, i;
    nop = mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    rst = 1;
    drive(nop);
    memAck = 0; memRData = 32'h0;
    modelReset();

    // Reset state.
    #3;
    check("rst_memReq", memReq, 1'b0);
    check("rst_stall", stallOutput, 1'b0);
    check("rst_valid", validOutput, 1'b0);
    check("rst_readData", readDataOutput, 32'h0);
    check("rst_result", ResultOutput, 32'h0);
    check("rst_pcSrc", pcSrcOutput, 2'd0);
    check("rst_timeout", timeoutOutput, 1'b0);
    #20;
    releaseReset(nop);

    // ADD: no memory flags, retires next edge.
    exec(mk(1,0,0,0,0,0,0, 32'h5, 32'h0, 32'h0, 32'h0, 5'd7), 0, 32'h0);
    @(negedge clk);
    check("add_stall", stallOutput, 1'b0);
    exec(nop, 0, 32'h0);
    check("add_result", ResultOutput, 32'h5);
    check("add_valid", validOutput, 1'b1);
    check("add_dest", regDestAddressOutput, 5'd7);

    // Branch taken, then branch with jump (jump wins).
    exec(mk(0,0,0,0,1,0,1, 32'h0, 32'h0, 32'h40, 32'h80, 5'd0), 0, 32'h0);
    @(negedge clk);
    check("br_pcSrc", pcSrcOutput, 2'd1);
    check("br_target", targetOutput, 32'h40);
    exec(mk(0,0,0,0,1,1,1, 32'h0, 32'h0, 32'h40, 32'h80, 5'd0), 0, 32'h0);
    @(negedge clk);
    check("jmp_pcSrc", pcSrcOutput, 2'd2);
    check("jmp_target", targetOutput, 32'h80);
    exec(mk(0,0,0,0,1,0,0, 32'h0, 32'h0, 32'h40, 32'h80, 5'd0), 0, 32'h0);

    // Load from 0x100, ack in third request cycle.
    stallCount = 0;
    exec(mk(1,1,1,0,0,0,0, 32'h100, 32'h0, 32'h0, 32'h0, 5'd9), 2, 32'hCAFEF00D);
    check("ld_addr_held", memAddr, 32'h100);
    exec(nop, 0, 32'h0);
    check("ld_stall_cycles", stallCount, 4);
    check("ld_readData", readDataOutput, 32'hCAFEF00D);
    check("ld_memToReg", MemToRegOutput, 1'b1);
    check("ld_valid", validOutput, 1'b1);
    check("ld_regWrite", regWriteFlagOutput, 1'b1);

    // Store 0x1234 to 0x104.
    exec(mk(1,0,0,1,0,0,0, 32'h104, 32'h1234, 32'h0, 32'h0, 5'd2), 0, 32'h0BAD0000);
    check("st_memWe", memWe, 1'b1);
    check("st_wdata", memWData, 32'h1234);
    exec(nop, 0, 32'h0);
    check("st_regWrite", regWriteFlagOutput, 1'b0);

    // Misaligned load at 0x102.
    exec(mk(1,1,1,0,0,0,0, 32'h102, 32'h0, 32'h0, 32'h0, 5'd4), 0, 32'h0);
    @(negedge clk);
    check("mis_memReq", memReq, 1'b0);
    exec(nop, 0, 32'h0);
    check("mis_alignErr", alignErrOutput, 1'b1);
    check("mis_regWrite", regWriteFlagOutput, 1'b0);
    exec(nop, 0, 32'h0);
    check("mis_alignErr_end", alignErrOutput, 1'b0);

    // Back-to-back loads; stray acks outside the access must be ignored.
    exec(mk(1,1,1,0,0,0,0, 32'h10C, 32'h0, 32'h0, 32'h0, 5'd5), 0, 32'h11111111);
    strayAck = 1;
    exec(mk(1,1,1,0,0,0,0, 32'h110, 32'h0, 32'h0, 32'h0, 5'd6), 0, 32'h22222222);
    exec(mk(1,0,0,0,0,0,0, 32'h77, 32'h0, 32'h0, 32'h0, 5'd1), 0, 32'h0);
    strayAck = 0;
    exec(nop, 0, 32'h0);
    check("stray_readData", readDataOutput, 32'h22222222);

    // Read and write both set: write wins.
    exec(mk(1,1,1,1,0,0,0, 32'h108, 32'h55, 32'h0, 32'h0, 5'd8), 1, 32'h0BAD0000);
    check("rw_memWe", memWe, 1'b1);
    exec(nop, 0, 32'h0);
    check("rw_regWrite", regWriteFlagOutput, 1'b0);

`ifdef MEM_TIMEOUT_EN
    execTimeoutLoad(mk(1,1,1,0,0,0,0, 32'h180, 32'h0, 32'h0, 32'h0, 5'd3));
    check("to_memReq_dropped", memReq, 1'b0);
    exec(nop, 0, 32'h0);
    check("to_readData", readDataOutput, 32'hDEADBEEF);
    exec(nop, 0, 32'h0);
    exec(nop, 0, 32'h0);
    check("to_sticky", timeoutOutput, 1'b1);
`endif

    // Reset in the middle of an access.
    i = mk(1,1,1,0,0,0,0, 32'h200, 32'h0, 32'h0, 32'h0, 5'd3);
    tick();
    drive(i);
    ePc = 0; eTgt = 0; memAck = 0; memRData = 32'h0;
    eReq = 0; eStall = 1; nxt.valid = 0; nxt.rw = 0;
    tick();
    eReq = 1; eStall = 1; eWe = 0; eAddr = 32'h200; eWData = 32'h0;
    @(posedge clk);
    cmpEn = 0;
    #2;
    rst = 1;
    #1;
    check("rstacc_memReq", memReq, 1'b0);
    check("rstacc_stall", stallOutput, 1'b0);
    check("rstacc_valid", validOutput, 1'b0);
    check("rstacc_memAddr", memAddr, 32'h0);
    check("rstacc_timeout", timeoutOutput, 1'b0);
    drive(nop);
    modelReset();
    #10;
    releaseReset(nop);
    exec(mk(1,0,0,0,0,0,0, 32'h9, 32'h0, 32'h0, 32'h0, 5'd3), 0, 32'h0);
    exec(nop, 0, 32'h0);
    check("post_rst_result", ResultOutput, 32'h9);
    exec(nop, 0, 32'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB boundary. It consumes the EX/MEM outputs and drives a word-wide data-memory request/acknowledge handshake. It stalls upstream while an access is outstanding, resolves branch/jump PC selection, and registers the MEM/WB values.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: ack watchdog limit (used only with MEM_TIMEOUT_EN)
- ERR_DATA, 32'hDEADBEEF: load data returned on timeout

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- regWriteFlagInput, MemToRegInput, memReadFlagInput, memWriteFlagInput, BranchsFlagInput, JumpsFlagInput, ZeroFlagInput  in  1 each  EX/MEM control/flags
- ResultInput  in  32  ALU result; this is the memory address
- BInput  in  32  store data
- regDestAddressInput  in  5  destination register
- BranchAddressInput, JumpAddressInput  in  32  branch and jump targets
- memReq  out  1  access request
- memWe  out  1  1 = write, 0 = read
- memAddr, memWData  out  32  address and write data
- memRData  in  32  read data; valid with memAck
- memAck  in  1  access complete
- stallOutput  out  1  hold EX/MEM; drives EX/MEM controlSignal low
- pcSrcOutput  out  2  0 = PC+4, 1 = branch, 2 = jump
- targetOutput  out  32  selected PC target
- regWriteFlagOutput, MemToRegOutput  out  1  MEM/WB controls
- readDataOutput, ResultOutput  out  32  MEM/WB data
- regDestAddressOutput  out  5  MEM/WB destination register
- validOutput  out  1  MEM/WB holds a real instruction
- alignErrOutput  out  1  one-cycle pulse on a misaligned access
- timeoutOutput  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0)

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE:**
  - An access occurs when memReadFlagInput or memWriteFlagInput is set and ResultInput[1:0] == 0. The FSM moves to ACCESS. stallOutput is asserted combinationally in this cycle.
  - If both read and write are set, the write wins and the read is ignored.
  - On a misaligned access (ResultInput[1:0] != 0), no request is issued and alignErrOutput pulses. The instruction retires with regWriteFlagOutput = 0.
  - A non-memory instruction retires directly with no stall.
- **ACCESS:**
  - memReq = 1, with memWe, memAddr and memWData registered at entry and held stable until ack.
  - stallOutput = 1.
  - When memAck is sampled high, readDataOutput captures memRData and the FSM moves to DONE.
- **DONE:**
  - stallOutput = 0 and memReq = 0.
  - The MEM/WB outputs load at the closing edge: validOutput = 1, readDataOutput stays as captured.
  - The FSM then returns to IDLE.
- **MEM/WB while stalled (IDLE-entry cycle and ACCESS):** validOutput = 0, regWriteFlagOutput = 0 (bubble). All other MEM/WB outputs hold.
- **Branch/jump resolution (combinational, non-memory path only):**
  - JumpsFlagInput: pcSrcOutput = 2, targetOutput = JumpAddressInput.
  - Otherwise BranchsFlagInput & ZeroFlagInput: pcSrcOutput = 1, targetOutput = BranchAddressInput.
  - Otherwise pcSrcOutput = 0, targetOutput = 0.
- memAck outside ACCESS is ignored.

## Timing
- **Reset values (async):** FSM = IDLE; all outputs 0, including memReq, stallOutput, validOutput, timeoutOutput and all data outputs.
- **Reset mid-ACCESS:** the request is dropped immediately. The memory side must tolerate an abandoned request.
- **Non-memory latency:** MEM/WB outputs are valid 1 edge after the EX/MEM values are presented.
- **Load/store latency:** with the instruction presented in cycle T, memReq is high from T+1. Fastest case is ack in T+1, DONE in T+2, MEM/WB valid after the T+2 edge. Each extra wait cycle adds one.
- **Stall pattern:** stallOutput is high in T through the ack cycle and low in DONE. EX/MEM therefore advances at the DONE edge, and the same instruction is never reissued.
- **Back-to-back accesses:** a second access is seen in IDLE the cycle after DONE, giving a minimum spacing of 3 cycles per access.

## Configuration
- **MEM_TIMEOUT_EN defined:**
  - An 8+ bit counter counts ACCESS cycles. If it reaches TIMEOUT_CYCLES without memAck, memReq drops and the FSM goes to DONE.
  - readDataOutput = ERR_DATA and timeoutOutput is set; timeoutOutput stays set until rst.
  - A store retires with no effect.
- **Not defined:** ACCESS waits indefinitely; no counter; timeoutOutput is tied 0.

## Test plan
- Reset asserted during ACCESS -> memReq, stallOutput and validOutput read 0 in the same cycle; FSM in IDLE.
- ADD (ResultInput = 32'h5, regWrite = 1), no memory flags -> stallOutput = 0; next edge gives ResultOutput = 5, validOutput = 1.
- Load from 32'h100, ack 3 cycles after memReq with memRData = 32'hCAFEF00D:
  - stallOutput is high 4 cycles; memAddr stays 32'h100 throughout.
  - readDataOutput = 32'hCAFEF00D, MemToRegOutput = 1, validOutput = 1 after DONE.
- Store with BInput = 32'h1234 to 32'h104 -> memWe = 1, memWData = 32'h1234 while memReq is high; regWriteFlagOutput = 0 at retire.
- Load at 32'h102 -> no memReq; alignErrOutput pulses for 1 cycle; regWriteFlagOutput = 0.
- Branch with ZeroFlagInput = 1 and BranchAddressInput = 32'h40 -> pcSrcOutput = 1, targetOutput = 32'h40. With JumpsFlagInput also set -> pcSrcOutput = 2.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> memReq drops after 4 cycles; readDataOutput = 32'hDEADBEEF; timeoutOutput stays 1 until rst.
